// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and types for the Dilithium coefficient recompose stream.
//   Q, GAMMA2, TWO_GAMMA2 : modulus and decomposition step sizes
//   N                     : coefficients per polynomial
//   state_t               : control FSM states of recompose_stream
//   t_t                   : signed width of the intermediate sum a1*2*GAMMA2 + a0
// -----------------------------------------------------------------------------
package dilithium_pkg;

  localparam int Q          = 8380417;
  localparam int GAMMA2     = (Q - 1) / 32;
  localparam int TWO_GAMMA2 = 2 * GAMMA2;
  localparam int N          = 256;

  localparam int A1_W  = 4;   // high part width
  localparam int A0_W  = 32;  // low part width (signed)
  localparam int A_W   = 23;  // reduced coefficient width, holds Q-1
  localparam int IDX_W = 8;   // coefficient index width, holds N-1

  // 15*TWO_GAMMA2 needs 23 bits; adding any 32-bit signed a0 fits in 34 signed.
  localparam int T_W = 34;
  typedef logic signed [T_W-1:0] t_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/recompose_core.sv
// -----------------------------------------------------------------------------
// recompose_core
// Purely combinational arithmetic for the recompose stream.
//   i_a1, i_a0   : incoming coefficient pair (a1 unsigned, a0 signed)
//   o_t          : a1*TWO_GAMMA2 + a0, full precision (first pipeline stage)
//   o_range_err  : a0 lies outside [-GAMMA2, GAMMA2]
//   i_t          : registered sum from the first stage
//   o_a          : i_t folded into [0, Q-1] by a single +Q / -Q correction
//                  (second pipeline stage)
// -----------------------------------------------------------------------------
module recompose_core
  import dilithium_pkg::*;
(
  input  logic [A1_W-1:0] i_a1,
  input  logic [A0_W-1:0] i_a0,
  input  t_t              i_t,
  output t_t              o_t,
  output logic            o_range_err,
  output logic [A_W-1:0]  o_a
);

  t_t                       w_a1_ext;
  t_t                       w_a0_ext;
  t_t                       w_fix;
  logic signed [A0_W-1:0]   w_a0_s;
  logic                     w_unused_hi;

  always_comb begin
    // NOTE: every signal driven here is assigned on every path through the
    // block, so no latch can be inferred.
    w_a1_ext    = {{(T_W-A1_W){1'b0}}, i_a1};
    w_a0_ext    = {{(T_W-A0_W){i_a0[A0_W-1]}}, i_a0};
    w_a0_s      = signed'(i_a0);
    o_t         = w_a1_ext * t_t'(TWO_GAMMA2) + w_a0_ext;
    o_range_err = (w_a0_s < -GAMMA2) || (w_a0_s > GAMMA2);

    if (i_t < 0) begin
      w_fix = i_t + t_t'(Q);
    end else if (i_t >= t_t'(Q)) begin
      w_fix = i_t - t_t'(Q);
    end else begin
      w_fix = i_t;
    end
    o_a = w_fix[A_W-1:0];
  end

  // After correction the upper bits carry no information for in-range sums.
  assign w_unused_hi = ^w_fix[T_W-1:A_W];

endmodule

// File: rtl/recompose_stream.sv
// -----------------------------------------------------------------------------
// recompose_stream
// Streams one polynomial of N coefficient pairs (a1, a0) and emits the
// recomposed coefficients a = (a1*2*GAMMA2 + a0) mod Q through a two-stage
// valid/ready pipeline.
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : begin a polynomial (honoured only when idle)
//   in_valid/in_ready           : input handshake, in_a1 (4b) / in_a0 (32b)
//   out_valid/out_ready         : output handshake
//   out_a, out_idx, out_last    : coefficient, its index, index == N-1 marker
//   busy                        : polynomial in progress (RUN or DRAIN)
//   done                        : one-cycle pulse after the final output
//   range_err                   : sticky, some accepted a0 was out of range
// -----------------------------------------------------------------------------
module recompose_stream
  import dilithium_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A1_W-1:0]   in_a1,
  input  logic [A0_W-1:0]   in_a0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [A_W-1:0]    out_a,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  state_t              r_state;
  logic [IDX_W-1:0]    r_in_cnt;
  logic [IDX_W-1:0]    r_out_cnt;
  logic                r_s1_valid;
  t_t                  r_s1_t;
  logic                r_out_valid;
  logic [A_W-1:0]      r_out_a;
  logic                r_busy;
  logic                r_done;
  logic                r_range_err;

  logic                w_en;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_out_last;
  t_t                  w_t;
  logic                w_range;
  logic [A_W-1:0]      w_a;

  recompose_core u_core (
    .i_a1        (in_a1),
    .i_a0        (in_a0),
    .i_t         (r_s1_t),
    .o_t         (w_t),
    .o_range_err (w_range),
    .o_a         (w_a)
  );

  // The whole pipeline advances together whenever the output slot is free or
  // being drained this cycle; otherwise both stages hold.
  assign w_en       = !r_out_valid || out_ready;
  assign in_ready   = (r_state == ST_RUN) && w_en;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_out_last = r_out_valid && (r_out_cnt == IDX_W'(N - 1));

  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_idx   = r_out_cnt;
  assign out_last  = w_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_range_err;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_t      <= '0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      if (w_en) begin
        r_s1_valid  <= w_in_xfer;
        if (w_in_xfer) r_s1_t <= w_t;
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_out_a <= w_a;
      end

      // Index follows emitted data, not accepted data, so stalls cannot skew it.
      if (w_out_xfer) r_out_cnt <= r_out_cnt + IDX_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_range_err <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_in_xfer) begin
            r_in_cnt <= r_in_cnt + IDX_W'(1);
            if (w_range) r_range_err <= 1'b1;
            if (r_in_cnt == IDX_W'(N - 1)) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_xfer && w_out_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recompose_stream.sv
// -----------------------------------------------------------------------------
// tb_recompose_stream
// Randomized scoreboard bench for recompose_stream. The driver pushes the
// expected coefficient whenever an input pair is accepted; an independent
// monitor pops and compares on every output transfer and also tracks the
// polynomial-level status (busy, done, range_err, in_ready) from the
// handshakes it observes.
// -----------------------------------------------------------------------------
module tb_recompose_stream;
  import dilithium_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [A1_W-1:0]   in_a1;
  logic [A0_W-1:0]   in_a0;
  logic              out_valid;
  logic              out_ready;
  logic [A_W-1:0]    out_a;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              range_err;

  typedef struct {
    longint a;
    longint idx;
    longint last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vprob    = 100;
  int   rprob    = 100;
  bit   abort_poly = 1'b0;

  recompose_stream dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a1     (in_a1),
    .in_a0     (in_a0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // (a1*2*GAMMA2 + a0) reduced mod Q with ordinary integer arithmetic.
  function automatic longint ref_recompose(input int a1, input int a0);
    longint t;
    t = longint'(a1) * TWO_GAMMA2 + longint'(a0);
    t = t % Q;
    if (t < 0) t = t + Q;
    return t;
  endfunction

  // Standard Dilithium decompose: centred remainder mod 2*GAMMA2, with the
  // r - r0 = Q-1 corner folded to a1 = 0.
  task automatic ref_decompose(input int r, output int a1, output int a0);
    int r0;
    r0 = r % TWO_GAMMA2;
    if (r0 > GAMMA2) r0 = r0 - TWO_GAMMA2;
    if (r - r0 == Q - 1) begin
      a1 = 0;
      a0 = r0 - 1;
    end else begin
      a1 = (r - r0) / TWO_GAMMA2;
      a0 = r0;
    end
  endtask

  function automatic bit a0_out_of_range(input logic [A0_W-1:0] v);
    int s;
    s = signed'(v);
    return (s < -GAMMA2) || (s > GAMMA2);
  endfunction

  // Downstream ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(99) < rprob);
    end
  end

  task automatic start_poly();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // kind 0: random in-range pairs; kind 1: directed values first;
  // kind 2: round trip of random r through decompose (expected = r).
  task automatic send_poly(input int kind, input int n_send, input int start_at,
                           input int bad_at, output int cycles);
    int a1s[4] = '{3, 0, 15, 0};
    int a0s[4] = '{5, -1, 261888, 0};
    longint exps[4] = '{1571333, 8380416, 8118528, 0};
    cycles = 0;
    for (int k = 0; k < n_send; k++) begin
      int     a1;
      int     a0;
      int     r;
      int     cyc;
      bit     got;
      longint e;
      exp_t   ent;
      if (abort_poly) break;
      a1 = int'($urandom_range(15));
      a0 = int'($urandom_range(TWO_GAMMA2)) - GAMMA2;
      if (k == bad_at) a0 = GAMMA2 + 1;
      e = ref_recompose(a1, a0);
      if (kind == 1 && k < 4) begin
        a1 = a1s[k];
        a0 = a0s[k];
        e  = exps[k];
      end else if (kind == 2) begin
        case (k)
          0:       r = Q - 1;
          1:       r = Q - 1 - GAMMA2 / 2;
          2:       r = 0;
          3:       r = GAMMA2;
          default: r = int'($urandom_range(Q - 1));
        endcase
        ref_decompose(r, a1, a0);
        e = longint'(r);
      end
      in_a1 = A1_W'(a1);
      in_a0 = A0_W'(a0);
      got = 1'b0;
      cyc = 0;
      while (!got && !abort_poly) begin
        in_valid = ($urandom_range(99) < vprob);
        if (k == start_at && cyc == 0) start = 1'b1;
        @(negedge clk);
        if (in_valid && in_ready) begin
          got      = 1'b1;
          ent.a    = e;
          ent.idx  = longint'(k);
          ent.last = (k == N - 1) ? 1 : 0;
          exp_q.push_back(ent);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        cycles++;
        if (!got && cyc > 500) begin
          n_checks++;
          n_fail++;
          $display("FAIL input_accept_timeout: actual=%0d cycles required<=500 at index %0d", cyc, k);
          abort_poly = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 3000);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: actual=%0d cycles required<3000", name, c);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares outputs against the scoreboard and the observed status
  // against a polynomial-level model advanced from the handshakes.
  initial begin
    bit            m_active = 1'b0;
    bit            m_done = 1'b0;
    bit            m_rng = 1'b0;
    bit            m_after_rst = 1'b0;
    bit            m_seen_out0 = 1'b0;
    bit            prev_stall = 1'b0;
    bit            last_x;
    int            m_in_cnt = 0;
    int            cyc = 0;
    int            t_in0 = 0;
    logic [A_W-1:0]   pa;
    logic [IDX_W-1:0] pi;
    logic             pl;
    exp_t          e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_active    = 1'b0;
        m_done      = 1'b0;
        m_rng       = 1'b0;
        m_in_cnt    = 0;
        m_after_rst = 1'b1;
        m_seen_out0 = 1'b0;
        prev_stall  = 1'b0;
        exp_q.delete();
        continue;
      end
      if (m_after_rst) begin
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_a", longint'(out_a), 0);
        check("rst_out_idx", longint'(out_idx), 0);
        check("rst_out_last", longint'(out_last), 0);
        m_after_rst = 1'b0;
      end
      check("busy", longint'(busy), longint'(m_active));
      check("done", longint'(done), longint'(m_done));
      check("range_err", longint'(range_err), longint'(m_rng));
      if (m_active && m_in_cnt < N)
        check("in_ready_run", longint'(in_ready), longint'(!out_valid || out_ready));
      else
        check("in_ready_closed", longint'(in_ready), 0);
      if (prev_stall) begin
        check("stall_valid", longint'(out_valid), 1);
        check("stall_a", longint'(out_a), longint'(pa));
        check("stall_idx", longint'(out_idx), longint'(pi));
        check("stall_last", longint'(out_last), longint'(pl));
      end
      if (out_valid && m_active && !m_seen_out0) begin
        check("first_latency", longint'(cyc - t_in0), 2);
        m_seen_out0 = 1'b1;
      end
      last_x = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: actual=%0d required=no output", out_a);
        end else begin
          e = exp_q.pop_front();
          check("out_a", longint'(out_a), e.a);
          check("out_idx", longint'(out_idx), e.idx);
          check("out_last", longint'(out_last), e.last);
          last_x = (e.last != 0);
        end
      end
      if (in_valid && in_ready) begin
        if (m_in_cnt == 0) t_in0 = cyc;
        m_in_cnt++;
        if (a0_out_of_range(in_a0)) m_rng = 1'b1;
      end
      if (start && !m_active && !m_done) begin
        m_active    = 1'b1;
        m_rng       = 1'b0;
        m_in_cnt    = 0;
        m_seen_out0 = 1'b0;
      end
      m_done = last_x;
      if (last_x) m_active = 1'b0;
      prev_stall = out_valid && !out_ready;
      pa = out_a;
      pi = out_idx;
      pl = out_last;
    end
  end

  initial begin
    int cycles;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_a1    = '0;
    in_a0    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed single values, full rate.
    vprob = 100; rprob = 100;
    start_poly();
    send_poly(1, N, -1, -1, cycles);
    wait_done("directed");

    // Out-of-range a0 at index 7.
    vprob = 80; rprob = 90;
    start_poly();
    send_poly(0, N, -1, 7, cycles);
    wait_done("range");

    // Round trip through decompose at full throughput.
    vprob = 100; rprob = 100;
    start_poly();
    send_poly(2, N, -1, -1, cycles);
    check("throughput_cycles", longint'(cycles), longint'(N));
    wait_done("roundtrip");

    // Random backpressure on both sides.
    vprob = 60; rprob = 50;
    start_poly();
    send_poly(0, N, -1, -1, cycles);
    wait_done("backpressure");

    // Reset after 100 inputs, then a fresh polynomial.
    vprob = 100; rprob = 70;
    start_poly();
    send_poly(0, 100, -1, -1, cycles);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    start_poly();
    send_poly(2, N, -1, -1, cycles);
    wait_done("after_reset");

    // Start pulsed while busy at index 50.
    vprob = 90; rprob = 80;
    start_poly();
    send_poly(0, N, 50, -1, cycles);
    wait_done("start_busy");

    repeat (5) @(posedge clk);
    check("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
